mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit that consumes the 4-bit `alucnt` code produced by the ALU control unit and executes the MIPS MULT, MULTU, DIV and DIVU operations over multiple cycles. It sits beside the single-cycle ALU in the execute stage. It holds its results in architectural HI/LO registers read by MFHI/MFLO, and exposes a start/busy/done handshake that the pipeline control uses to stall.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width. Iteration count equals `WIDTH`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset. Asynchronous and active-low.
- `start`  input  1  request. Sampled only in IDLE.
- `alucnt`  input  4  operation select: 4'b1000 MULT, 4'b1001 MULTU, 4'b1010 DIV, 4'b1011 DIVU. Any other code is ignored.
- `a`  input  WIDTH  rs operand (multiplicand / dividend).
- `b`  input  WIDTH  rt operand (multiplier / divisor).
- `busy`  output  1  high while an operation is in flight.
- `done`  output  1  one-cycle pulse when HI/LO hold a new result.
- `div_by_zero`  output  1  one-cycle pulse, coincident with `done`, for DIV/DIVU with `b == 0`.
- `hi`  output  WIDTH  HI register: upper product half, or remainder.
- `lo`  output  WIDTH  LO register: lower product half, or quotient.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - `start` high with a valid `alucnt` latches `a`, `b`, the operation and signedness.
  - MULT/MULTU goes to MUL.
  - DIV/DIVU with `b != 0` goes to DIV.
  - DIV/DIVU with `b == 0` goes straight to FIX with a zero-flag set.
  - `start` with an invalid code does nothing.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at latch time.
  - The sign of the result is recorded at latch time.
  - Unsigned ops use the operands as-is.
- MUL: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, exactly WIDTH cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles, then FIX.
- FIX (one cycle):
  - Product is negated (2·WIDTH two's complement) when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - `{hi,lo}` or `{remainder,quotient}` is written.
  - Return to IDLE.
- Divide by zero: `hi`/`lo` are left unchanged and `div_by_zero` pulses.
- DIV of 0x80000000 by 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0. No flag.
- All arithmetic is modulo 2^WIDTH (or 2^(2·WIDTH) for products). No overflow flag.
- `start` while `busy` is ignored. The in-flight operation is unaffected.
- Input changes on `a`, `b` or `alucnt` after latch have no effect.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `div_by_zero` = 0.
  - `hi` = 0, `lo` = 0.
  - State is IDLE.
- Reset asserted mid-operation aborts immediately. HI/LO clear to 0 and no `done` is issued.
- Start is accepted at edge E0. `busy` is 1 from after E0 until after E(WIDTH+1).
- HI/LO update at edge E(WIDTH+1), which is E33 for WIDTH=32.
- `done` is high for exactly the cycle following that edge, with `busy` already 0 in that cycle.
- A new `start` may be sampled in the same cycle that `done` is high, giving back-to-back ops with no bubble.
- Divide by zero timing:
  - Latch at E0, FIX at E1.
  - `done` and `div_by_zero` are high in the cycle after E1.
  - `busy` is high only between E0 and E1.
- `hi` and `lo` are registered and stable between updates.

## Test plan
- MULTU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` pulses 34 cycles after the start edge.
- MULT `a`=0xFFFFFFFD (−3), `b`=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV `a`=0xFFFFFFF9 (−7), `b`=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIVU `a`=100, `b`=7 -> `lo`=0xE, `hi`=2. The second start is issued in the first op's `done` cycle.
- DIV `a`=0x80000000, `b`=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. Then DIVU `a`=5, `b`=0 -> `done` and `div_by_zero` high 2 cycles after start, with `hi`/`lo` unchanged.
- Start with `alucnt`=4'b0010 -> `busy` stays 0 and no `done`. A second start while `busy` -> ignored, and the result equals the first op's result.
- Assert `rst_n`=0 at iteration 10 of a MULTU -> `busy`, `hi`, `lo` read 0 immediately and no `done` follows.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alucnt,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   localparam int CW = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
   logic [WIDTH-1:0]   bop_q, bop_d;     // multiplicand magnitude or divisor magnitude
   logic               is_div_q, is_div_d;
   logic               signed_q, signed_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               neg_res;

   // Next-state logic: latch in IDLE, iterate in MUL/DIV, sign-correct and write back in FIX
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      bop_d    = bop_q;
      is_div_d = is_div_q;
      signed_d = signed_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      zero_d   = zero_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dbz_d    = 1'b0;

      a_mag    = (!alucnt[0] && a[WIDTH-1]) ? -a : a;
      b_mag    = (!alucnt[0] && b[WIDTH-1]) ? -b : b;
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, bop_q};
      div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, bop_q};
      neg_res  = signed_q & (sa_q ^ sb_q);
      prod_fix = neg_res ? -acc_q : acc_q;
      quo_fix  = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = (signed_q && sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      case (state_q)
         S_IDLE: begin
            if (start && alucnt[3:2] == 2'b10) begin
               signed_d = ~alucnt[0];
               is_div_d = alucnt[1];
               sa_d     = a[WIDTH-1];
               sb_d     = b[WIDTH-1];
               cnt_d    = '0;
               zero_d   = alucnt[1] && (b == '0);
               if (alucnt[1]) begin
                  bop_d = b_mag;
                  acc_d = {{WIDTH{1'b0}}, a_mag};
                  state_d = (b == '0) ? S_FIX : S_DIV;
               end else begin
                  bop_d = a_mag;
                  acc_d = {{WIDTH{1'b0}}, b_mag};
                  state_d = S_MUL;
               end
            end
         end
         S_MUL: begin
            if (acc_q[0]) begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end else begin
               acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = S_FIX;
            end
         end
         S_DIV: begin
            if (!div_diff[WIDTH+1]) begin
               acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (zero_q) begin
               dbz_d = 1'b1;
            end else if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation and clears HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         bop_q    <= '0;
         is_div_q <= 1'b0;
         signed_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         zero_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         bop_q    <= bop_d;
         is_div_q <= is_div_d;
         signed_q <= signed_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         zero_q   <= zero_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule
